clus_pattern_check: RTL and testbench

- Receive-side checker for the simulated-cluster event stream written into SIM_ROC_FIFO.
- Pops one event at a time: a header word, then N payload words.
- Decodes header size and tag, verifies the payload against the expected counter or 5/A pattern, and keeps saturating error counters.
- Sits on the FIFO read port and is used for loopback verification of the pattern generator and the DDR path.

---
 rtl/clus_pattern_check.sv | 195 +++++++++++++++++++
 tb/tb_clus_pattern_check.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clus_pattern_check.sv
// clus_pattern_check
//   Receive-side checker for the simulated-cluster event stream read from
//   SIM_ROC_FIFO. Each event is one header word {size[11:0], tag[19:0]}
//   followed by 'size' payload words. The payload is checked against a running
//   32-bit counter (pattern_type = 0) or an alternating 0x55../0xAA.. pattern
//   (pattern_type = 1). Data and tag errors are counted in saturating counters.
//
//   Optional build macro: CLUS_PATTERN_FIRST_ERR_EN adds first-mismatch capture
//   outputs (first_err_vld/exp/got/word/tag).
//
// Ports
//   serdesclk        clock
//   serdesclk_reset  synchronous active-high reset
//   newspill_reset   synchronous spill restart (keeps payload expectation if haltrun_en)
//   haltrun_en       hold exp_data / pat_idx across newspill_reset
//   pattern_type     0 = counter payload, 1 = 0x55/0xAA alternating payload
//   fifo_empty       FIFO empty flag
//   fifo_rdata       FIFO read data, valid the cycle after fifo_re
//   fifo_re          FIFO read enable
//   evt_done         one-cycle pulse per completed event
//   evt_size/evt_tag header fields of the last completed event
//   evt_cnt          events completed this spill
//   data_err_cnt     mismatched payload words (saturating)
//   tag_err_cnt      headers whose tag is not previous tag + 1 (saturating)
//   busy             event in progress
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a header word; issues the header read
// HDR   | header read in flight; decode size/tag when it lands
// PAY   | issuing and checking payload reads
// DONE  | event complete; publish results, pulse evt_done next cycle
module clus_pattern_check #(
    parameter int DIGI_BITS      = 32,
    parameter int SPILL_TAG_BITS = 20,
    parameter int ERRCNT_BITS    = 16
) (
    input  logic                      serdesclk,
    input  logic                      serdesclk_reset,
    input  logic                      newspill_reset,
    input  logic                      haltrun_en,
    input  logic                      pattern_type,
    input  logic                      fifo_empty,
    input  logic [DIGI_BITS-1:0]      fifo_rdata,
    output logic                      fifo_re,
    output logic                      evt_done,
    output logic [11:0]               evt_size,
    output logic [SPILL_TAG_BITS-1:0] evt_tag,
    output logic [ERRCNT_BITS-1:0]    evt_cnt,
    output logic [ERRCNT_BITS-1:0]    data_err_cnt,
    output logic [ERRCNT_BITS-1:0]    tag_err_cnt,
    output logic                      busy
`ifdef CLUS_PATTERN_FIRST_ERR_EN
    ,
    output logic                      first_err_vld,
    output logic [DIGI_BITS-1:0]      first_err_exp,
    output logic [DIGI_BITS-1:0]      first_err_got,
    output logic [11:0]               first_err_word,
    output logic [SPILL_TAG_BITS-1:0] first_err_tag
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_DONE} state_t;

    localparam logic [DIGI_BITS-1:0] PAT_5 = {(DIGI_BITS/2){2'b01}};
    localparam logic [DIGI_BITS-1:0] PAT_A = {(DIGI_BITS/2){2'b10}};

    state_t                    state, state_nxt;
    logic                      rd_vld;
    logic [11:0]               cur_size;
    logic [SPILL_TAG_BITS-1:0] cur_tag;
    logic [SPILL_TAG_BITS-1:0] last_tag;
    logic                      tag_armed;
    logic [11:0]               rd_left;   // payload reads still to issue
    logic [11:0]               rv_left;   // payload words still to receive
    logic [DIGI_BITS-1:0]      exp_data;
    logic                      pat_idx;

    logic [11:0]               hdr_size;
    logic [SPILL_TAG_BITS-1:0] hdr_tag;
    logic [SPILL_TAG_BITS-1:0] tag_next;
    logic                      hdr_vld;
    logic                      pay_vld;
    logic [DIGI_BITS-1:0]      exp_word;
    logic                      word_err;
    logic                      spill_clr;

    assign hdr_size  = fifo_rdata[DIGI_BITS-1 -: 12];
    assign hdr_tag   = fifo_rdata[SPILL_TAG_BITS-1:0];
    assign tag_next  = last_tag + 1'b1;
    assign hdr_vld   = (state == S_HDR) && rd_vld;
    assign pay_vld   = (state == S_PAY) && rd_vld;
    assign exp_word  = pattern_type ? (pat_idx ? PAT_A : PAT_5) : exp_data;
    assign word_err  = pay_vld && (fifo_rdata != exp_word);
    assign spill_clr = serdesclk_reset || newspill_reset;

    always_ff @(posedge serdesclk) begin
        if (spill_clr) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!fifo_empty) state_nxt = S_HDR;
            S_HDR:   if (rd_vld) state_nxt = (hdr_size == 12'd0) ? S_DONE : S_PAY;
            S_PAY:   if (rd_vld && rv_left == 12'd1) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_re = 1'b0;
        busy    = (state != S_IDLE);
        case (state)
            S_IDLE:  fifo_re = !fifo_empty;
            S_PAY:   fifo_re = !fifo_empty && (rd_left != 12'd0);
            default: fifo_re = 1'b0;
        endcase
    end

    // Payload expectation survives a spill restart while the run is halted.
    always_ff @(posedge serdesclk) begin
        if (serdesclk_reset || (newspill_reset && !haltrun_en)) begin
            exp_data <= '0;
            pat_idx  <= 1'b0;
        end else if (!newspill_reset && pay_vld) begin
            if (pattern_type) pat_idx  <= ~pat_idx;
            else              exp_data <= exp_data + 1'b1;
        end
    end

    always_ff @(posedge serdesclk) begin
        if (spill_clr) begin
            rd_vld       <= 1'b0;
            cur_size     <= '0;
            cur_tag      <= '0;
            last_tag     <= '0;
            tag_armed    <= 1'b0;
            rd_left      <= '0;
            rv_left      <= '0;
            evt_done     <= 1'b0;
            evt_size     <= '0;
            evt_tag      <= '0;
            evt_cnt      <= '0;
            data_err_cnt <= '0;
            tag_err_cnt  <= '0;
        end else begin
            rd_vld   <= fifo_re;
            evt_done <= (state == S_DONE);

            if (hdr_vld) begin
                cur_size  <= hdr_size;
                cur_tag   <= hdr_tag;
                rd_left   <= hdr_size;
                rv_left   <= hdr_size;
                tag_armed <= 1'b1;
                if (tag_armed && hdr_tag != tag_next && tag_err_cnt != '1)
                    tag_err_cnt <= tag_err_cnt + 1'b1;
            end

            if (state == S_PAY && fifo_re) rd_left <= rd_left - 1'b1;
            if (pay_vld)                   rv_left <= rv_left - 1'b1;
            if (word_err && data_err_cnt != '1)
                data_err_cnt <= data_err_cnt + 1'b1;

            if (state == S_DONE) begin
                evt_size <= cur_size;
                evt_tag  <= cur_tag;
                last_tag <= cur_tag;
                evt_cnt  <= evt_cnt + 1'b1;
            end
        end
    end

`ifdef CLUS_PATTERN_FIRST_ERR_EN
    always_ff @(posedge serdesclk) begin
        if (spill_clr) begin
            first_err_vld  <= 1'b0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            first_err_word <= '0;
            first_err_tag  <= '0;
        end else if (word_err && !first_err_vld) begin
            first_err_vld  <= 1'b1;
            first_err_exp  <= exp_word;
            first_err_got  <= fifo_rdata;
            first_err_word <= cur_size - rv_left;
            first_err_tag  <= cur_tag;
        end
    end
`endif

endmodule

// File: tb/tb_clus_pattern_check.sv
module tb_clus_pattern_check;

    logic        serdesclk;
    logic        serdesclk_reset;
    logic        newspill_reset;
    logic        haltrun_en;
    logic        pattern_type;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        fifo_re;
    logic        evt_done;
    logic [11:0] evt_size;
    logic [19:0] evt_tag;
    logic [15:0] evt_cnt;
    logic [15:0] data_err_cnt;
    logic [15:0] tag_err_cnt;
    logic        busy;
`ifdef CLUS_PATTERN_FIRST_ERR_EN
    logic        first_err_vld;
    logic [31:0] first_err_exp;
    logic [31:0] first_err_got;
    logic [11:0] first_err_word;
    logic [19:0] first_err_tag;
`endif

    clus_pattern_check dut (
        .serdesclk       (serdesclk),
        .serdesclk_reset (serdesclk_reset),
        .newspill_reset  (newspill_reset),
        .haltrun_en      (haltrun_en),
        .pattern_type    (pattern_type),
        .fifo_empty      (fifo_empty),
        .fifo_rdata      (fifo_rdata),
        .fifo_re         (fifo_re),
        .evt_done        (evt_done),
        .evt_size        (evt_size),
        .evt_tag         (evt_tag),
        .evt_cnt         (evt_cnt),
        .data_err_cnt    (data_err_cnt),
        .tag_err_cnt     (tag_err_cnt),
        .busy            (busy)
`ifdef CLUS_PATTERN_FIRST_ERR_EN
        ,
        .first_err_vld   (first_err_vld),
        .first_err_exp   (first_err_exp),
        .first_err_got   (first_err_got),
        .first_err_word  (first_err_word),
        .first_err_tag   (first_err_tag)
`endif
    );

    initial serdesclk = 1'b0;
    always #5 serdesclk = ~serdesclk;

    int n_pass  = 0;
    int n_total = 0;

    // FIFO model: 'stage' holds words not yet visible, 'q' is the FIFO content
    logic [31:0] q[$];
    logic [31:0] stage[$];
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int pop_cyc  = 0;
    int viol     = 0;

    // reference model state
    logic [31:0] m_exp;
    logic        m_pidx;
    logic [19:0] m_last;
    logic        m_armed;
    int          m_evt, m_derr, m_terr;
    logic [11:0] m_size;
    logic [19:0] m_tag;
    logic        m_fe_vld;
    logic [31:0] m_fe_exp, m_fe_got;
    logic [11:0] m_fe_word;
    logic [19:0] m_fe_tag;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_clear(input bit keep_exp);
        m_evt = 0; m_derr = 0; m_terr = 0;
        m_size = '0; m_tag = '0; m_last = '0; m_armed = 1'b0;
        m_fe_vld = 1'b0; m_fe_exp = '0; m_fe_got = '0; m_fe_word = '0; m_fe_tag = '0;
        if (!keep_exp) begin
            m_exp  = '0;
            m_pidx = 1'b0;
        end
    endtask

    // One clock: sample DUT at negedge, apply FIFO side effects after posedge.
    task automatic step();
        logic re_now;
        @(negedge serdesclk);
        re_now = fifo_re;
        if (fifo_re && fifo_empty) viol++;
        if (evt_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge serdesclk);
        #1;
        if (re_now && q.size() > 0) begin
            fifo_rdata = q.pop_front();
            pop_cyc    = cyc;
        end else begin
            fifo_rdata = $urandom;
        end
        fifo_empty = (q.size() == 0);
        cyc++;
    endtask

    task automatic release_words(input int n);
        for (int i = 0; i < n && stage.size() > 0; i++) q.push_back(stage.pop_front());
        fifo_empty = (q.size() == 0);
    endtask

    // Builds an event into 'stage' and advances the model over the first nwords
    // payload words. bad = index of a corrupted word, -2 = every word corrupted.
    task automatic push_event(input int size, input logic [19:0] tag, input int bad, input int nwords);
        logic [31:0] exp_w;
        logic [31:0] w;
        logic [11:0] sz;
        sz = size[11:0];
        stage.push_back({sz, tag});
        if (m_armed && tag != m_last + 20'd1) m_terr = sat(m_terr);
        m_armed = 1'b1;
        for (int i = 0; i < nwords; i++) begin
            exp_w = pattern_type ? (m_pidx ? 32'hAAAA_AAAA : 32'h5555_5555) : m_exp;
            if (bad == -2 || bad == i) w = pattern_type ? 32'h0 : (exp_w ^ 32'h8000_0000);
            else                       w = exp_w;
            stage.push_back(w);
            if (w != exp_w) begin
                m_derr = sat(m_derr);
                if (!m_fe_vld) begin
                    m_fe_vld = 1'b1; m_fe_exp = exp_w; m_fe_got = w;
                    m_fe_word = 12'(i); m_fe_tag = tag;
                end
            end
            if (pattern_type) m_pidx = !m_pidx;
            else              m_exp  = m_exp + 32'd1;
        end
        if (nwords == int'(sz)) begin
            m_evt++;
            m_size = sz;
            m_tag  = tag;
            m_last = tag;
        end
    endtask

    task automatic wait_done(input string pfx, input int n, input int bound);
        int target;
        int k;
        target = done_cnt + n;
        k = 0;
        while (done_cnt < target && k < bound) begin
            step();
            k++;
        end
        chk({pfx, ".done_seen"}, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, ".evt_cnt"},      32'(evt_cnt),      32'(m_evt));
        chk({pfx, ".data_err_cnt"}, 32'(data_err_cnt), 32'(m_derr));
        chk({pfx, ".tag_err_cnt"},  32'(tag_err_cnt),  32'(m_terr));
        chk({pfx, ".evt_size"},     32'(evt_size),     32'(m_size));
        chk({pfx, ".evt_tag"},      32'(evt_tag),      32'(m_tag));
`ifdef CLUS_PATTERN_FIRST_ERR_EN
        chk({pfx, ".first_err_vld"},  32'(first_err_vld),  32'(m_fe_vld));
        chk({pfx, ".first_err_exp"},  first_err_exp,       m_fe_exp);
        chk({pfx, ".first_err_got"},  first_err_got,       m_fe_got);
        chk({pfx, ".first_err_word"}, 32'(first_err_word), 32'(m_fe_word));
        chk({pfx, ".first_err_tag"},  32'(first_err_tag),  32'(m_fe_tag));
`endif
    endtask

    task automatic do_reset();
        serdesclk_reset = 1'b1;
        q.delete();
        stage.delete();
        fifo_empty = 1'b1;
        repeat (2) step();
        serdesclk_reset = 1'b0;
        model_clear(1'b0);
    endtask

    initial begin
        int d0;
        logic [19:0] tg;
        int sz;
        logic [19:0] gap_tags [3];

        serdesclk_reset = 1'b1;
        newspill_reset  = 1'b0;
        haltrun_en      = 1'b0;
        pattern_type    = 1'b0;
        fifo_empty      = 1'b1;
        fifo_rdata      = '0;
        model_clear(1'b0);

        // reset state
        do_reset();
        step();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.fifo_re", 32'(fifo_re), 32'd0);
        chk("rst.evt_done_cnt", 32'(done_cnt), 32'd0);
        check_all("rst");

        // counter mode, two back-to-back events preloaded
        pattern_type = 1'b0;
        push_event(16, 20'd1, -1, 16);
        push_event(8, 20'd2, -1, 8);
        release_words(stage.size());
        d0 = done_cnt;
        wait_done("cnt", 2, 200);
        repeat (5) step();
        chk("cnt.pulses", 32'(done_cnt - d0), 32'd2);
        check_all("cnt");

        // pattern mode, clean event then word 5 corrupted
        do_reset();
        pattern_type = 1'b1;
        push_event(24, 20'd0, -1, 24);
        release_words(stage.size());
        wait_done("pat0", 1, 200);
        check_all("pat0");
        push_event(24, 20'd1, 5, 24);
        release_words(stage.size());
        wait_done("pat1", 1, 200);
        check_all("pat1");

        // tag gap with zero-size headers
        do_reset();
        pattern_type = 1'b0;
        gap_tags[0] = 20'd3; gap_tags[1] = 20'd4; gap_tags[2] = 20'd6;
        for (int i = 0; i < 3; i++) begin
            push_event(0, gap_tags[i], -1, 0);
            release_words(stage.size());
            wait_done($sformatf("gap%0d", i), 1, 50);
            chk($sformatf("gap%0d.latency", i), 32'(done_cyc - pop_cyc), 32'd3);
        end
        check_all("gap");

        // FIFO underflow stall mid-event
        do_reset();
        viol = 0;
        push_event(8, 20'd0, -1, 8);
        release_words(4);
        d0 = done_cnt;
        repeat (20) step();
        chk("stall.busy", 32'(busy), 32'd1);
        chk("stall.no_done", 32'(done_cnt - d0), 32'd0);
        release_words(stage.size());
        wait_done("stall", 1, 100);
        chk("stall.latency", 32'(done_cyc - pop_cyc), 32'd3);
        chk("stall.re_while_empty", 32'(viol), 32'd0);
        check_all("stall");

        // newspill mid-event, expectation held then cleared
        for (int h = 1; h >= 0; h--) begin
            do_reset();
            haltrun_en = h[0];
            pattern_type = 1'b0;
            if (h == 0) begin
                // move the counter away from zero so a clear is observable
                push_event(3, 20'd0, -1, 3);
                release_words(stage.size());
                wait_done("ns_pre", 1, 100);
            end
            push_event(200, 20'd5, -1, 100);
            release_words(stage.size());
            d0 = done_cnt;
            repeat (120) step();
            chk($sformatf("ns%0d.busy_mid", h), 32'(busy), 32'd1);
            newspill_reset = 1'b1;
            step();
            newspill_reset = 1'b0;
            model_clear(h[0]);
            step();
            chk($sformatf("ns%0d.no_done", h), 32'(done_cnt - d0), 32'd0);
            chk($sformatf("ns%0d.busy_after", h), 32'(busy), 32'd0);
            chk($sformatf("ns%0d.evt_cnt", h), 32'(evt_cnt), 32'd0);
            push_event(4, 20'd9, -1, 4);
            release_words(stage.size());
            wait_done($sformatf("ns%0d", h), 1, 100);
            check_all($sformatf("ns%0d", h));
        end

        // randomized events
        do_reset();
        haltrun_en = 1'b0;
        for (int e = 0; e < 30; e++) begin
            pattern_type = 1'($urandom_range(0, 1));
            sz = $urandom_range(0, 12);
            tg = m_last + 20'd1 + (($urandom_range(0, 4) == 0) ? 20'd1 : 20'd0);
            push_event(sz, tg, $urandom_range(0, 15), sz);
            release_words(stage.size());
            wait_done($sformatf("rnd%0d", e), 1, 100);
            check_all($sformatf("rnd%0d", e));
        end

        // data error counter saturation: 16 x 4095 + 20 = 65540 bad words
        do_reset();
        pattern_type = 1'b1;
        for (int e = 0; e < 17; e++) begin
            sz = (e < 16) ? 4095 : 20;
            push_event(sz, 20'(e), -2, sz);
            release_words(stage.size());
            wait_done($sformatf("sat%0d", e), 1, 4200);
        end
        chk("sat.data_err_cnt", 32'(data_err_cnt), 32'h0000_FFFF);
        check_all("sat");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
